// File: rtl/mem_bridge_if.sv
// mem_bridge_if: CPU-side load/store handshake between the core (master) and mem_bridge (slave).
interface mem_bridge_if;
    logic        Memread;
    logic        Memwrite;
    logic [31:0] Addr;
    logic [31:0] Memout;
    logic [31:0] Memin;
    logic        mem_ready;
    logic        bus_err;
    modport master (output Memread, Memwrite, Addr, Memout, input Memin, mem_ready, bus_err);
    modport slave  (input Memread, Memwrite, Addr, Memout, output Memin, mem_ready, bus_err);
endinterface

// File: rtl/mem_bridge.sv
// mem_bridge: runs CPU loads/stores against a synchronous word RAM or a two-word I/O window
// with uniform fixed latency, returning registered Memin plus one-cycle mem_ready/bus_err strobes.
module mem_bridge #(
    parameter int          RAM_AW      = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] IO_BASE     = 32'hFFFF0000
) (
    input  logic              clk,
    input  logic              rst,
    mem_bridge_if.slave       bus,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [15:0]       io_out
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {K_RAM, K_IO0, K_IO1, K_ERR} kind_t;

    state_t            r_state, w_next;
    kind_t             r_kind, w_kind;
    logic              r_rd, r_wr, w_accept, w_last;
    logic [RAM_AW-1:0] r_waddr;
    logic [31:0]       r_wdata, r_memin, r_cyc;
    logic [15:0]       r_io;
    logic [3:0]        r_wcnt;

    always_comb begin
        w_kind = (bus.Addr[1:0] != 2'b00 || (bus.Memread && bus.Memwrite)) ? K_ERR :
                 (bus.Addr[31:RAM_AW+2] == '0)                            ? K_RAM :
                 (bus.Addr == IO_BASE)                                    ? K_IO0 :
                 (bus.Addr == IO_BASE + 32'd4)                            ? K_IO1 : K_ERR;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.Memread || bus.Memwrite) begin
                    w_next   = ACCESS;
                    w_accept = 1'b1;
                end
            end
            ACCESS:  w_next = (r_wcnt == 4'd0) ? RESP : ACCESS;
            default: w_next = IDLE;
        endcase
    end

    assign w_last        = (r_state == ACCESS) && (r_wcnt == 4'd0);
    assign ram_en        = (r_state == ACCESS) && (r_kind == K_RAM);
    // store data is written once, in the first ACCESS cycle
    assign ram_we        = ram_en && r_wr && (r_wcnt == 4'(WAIT_CYCLES));
    assign ram_addr      = r_waddr;
    assign ram_wdata     = r_wdata;
    assign io_out        = r_io;
    assign bus.Memin     = r_memin;
    assign bus.mem_ready = (r_state == RESP);
    assign bus.bus_err   = (r_state == RESP) && (r_kind == K_ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_kind  <= K_RAM;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_memin <= '0;
            r_cyc   <= '0;
            r_io    <= '0;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_next;
            r_cyc   <= r_cyc + 32'd1;
            if (w_accept) begin
                r_kind  <= w_kind;
                r_rd    <= bus.Memread;
                r_wr    <= bus.Memwrite;
                r_waddr <= bus.Addr[RAM_AW+1:2];
                r_wdata <= bus.Memout;
                r_wcnt  <= 4'(WAIT_CYCLES);
            end else if (r_state == ACCESS && r_wcnt != 4'd0) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
            if (w_last) begin
                if (r_kind == K_ERR)
                    r_memin <= '0;
                else if (r_rd)
                    r_memin <= (r_kind == K_RAM) ? ram_rdata :
                               (r_kind == K_IO0) ? {16'h0, r_io} : r_cyc;
                if (r_kind == K_IO0 && r_wr)
                    r_io <= r_wdata[15:0];
            end
        end
    end
endmodule
